relax_writeback_stage: RTL and testbench
========================================

// Module: relax_writeback_stage
// PURPOSE
//   Bellman-Ford relax stage; sits directly downstream of the 4-word pipeline register.
//   Consumes {u_dist, weight, v_dist, v_idx} for one edge per cycle.
//   Computes cand = u_dist + weight. When cand < v_dist, issues a distance-memory write to v_idx.
//   Tracks per-pass change status and relaxation count, and signals pass completion to the iteration controller.
// PARAMETERS
//   WORD_SIZE  8   width of distances, weights, vertex indices (matches pipeline register)
//   CNT_SIZE   16  width of relax_count
// PORTS
//   clk          in   1          rising-edge clock
//   clear        in   1          synchronous, active-high reset
//   enable       in   1          stage advance; 0 = stall (all state holds)
//   pass_start   in   1          pulse: begin a new pass
//   valid_in     in   1          in_data1..4 carry a valid edge
//   last_edge    in   1          qualifies valid_in: final edge of the pass
//   u_idx        in   WORD_SIZE  source vertex index (forwarding compare only)
//   in_data1     in   WORD_SIZE  u_dist, signed two's complement
//   in_data2     in   WORD_SIZE  weight, signed
//   in_data3     in   WORD_SIZE  v_dist, signed
//   in_data4     in   WORD_SIZE  v_idx, unsigned
//   wr_en        out  1          distance-memory write strobe
//   wr_addr      out  WORD_SIZE  write index (v_idx)
//   wr_data      out  WORD_SIZE  new distance
//   changed      out  1          sticky: at least one write this pass
//   relax_count  out  CNT_SIZE   writes this pass, saturating at all-ones
//   pass_done    out  1          one-cycle pulse at end of pass
//   busy         out  1          FSM not in IDLE
// BEHAVIOUR
//   Reset: clear=1 at an edge forces all outputs to 0 and the FSM to IDLE, regardless of enable.
//     Also applies mid-pass: an in-flight write is dropped.
//   INF = {1'b0,{WORD_SIZE-1{1'b1}}} (max positive); it means unreached.
//   Arithmetic uses WORD_SIZE+1-bit signed add. cand is clamped to [MIN_NEG, INF-1], so it never equals INF.
//   Improve = valid_in & state==RUN & u_dist!=INF & cand<v_dist (signed compare).
//   Latency: 1 cycle. The edge is sampled at clock edge N with enable=1.
//     wr_en/addr/data are registered and visible after edge N and for one cycle only.
//   When enable=0 at an edge: wr_en registers 0 (no repeated write); every other register holds.
//   If valid_in=1 while the FSM is IDLE or DONE, the edge is ignored; no write and no count.
//   FSM (advances only when enable=1):
//     IDLE  -pass_start->                     RUN   (changed, relax_count cleared)
//     RUN   -valid_in & last_edge->           DRAIN (that edge is still processed)
//     DRAIN -1 cycle->                        DONE  (last write retires)
//     DONE  -1 cycle->                        IDLE  (pass_done=1 exactly in DONE cycle)
//   pass_start outside IDLE is ignored.
//   changed sets on the same edge as wr_en; relax_count increments on the same edge as wr_en.
//     Both hold through IDLE until the next pass_start.
//   relax_count saturates at 2^CNT_SIZE-1 (no wrap).
// CONFIGURATION
//   RELAX_FWD_EN defined: single-entry write forwarding.
//     If wr_en=1 and wr_addr==in_data4, wr_data replaces v_dist.
//     If wr_en=1 and wr_addr==u_idx, wr_data replaces u_dist.
//     Forwarded values are substituted before the add/compare.
//     Back-to-back edges on the same vertex then relax correctly.
//   RELAX_FWD_EN undefined: no compare logic; u_idx is unused.
//     Upstream must space dependent edges by >=2 cycles.
// TESTING
//   1. pass_start; edge u=3,w=2,v=9,idx=5 -> next cycle wr_en=1, addr=5, data=5; changed=1, count=1.
//   2. u=INF, w=-1, v=INF, idx=2 -> no write; u=4, w=4, v=8 -> no write (equal is not improvement).
//   3. WORD_SIZE=8: u=120, w=100, v=INF -> wr_data=126 (clamped); u=-100, w=-100 -> wr_data=-128.
//   4. RELAX_FWD_EN: edge (u=0,w=1,v=50,idx=7) then edge (u=0,w=3,v=50,idx=7) next cycle
//        -> first writes 1; second sees forwarded v=1 and does not write. Without macro: second writes 3.
//   5. last_edge on the 3rd edge -> DRAIN, DONE, pass_done pulse 2 cycles after that edge;
//        enable=0 for 2 cycles in DRAIN -> pass_done delayed by 2, wr_en not repeated.
//   6. clear asserted the cycle after an improving edge -> wr_en=0, changed=0, count=0, busy=0 next cycle.

Source files
------------

// File: rtl/relax_writeback_stage.sv
// Bellman-Ford relax/writeback stage: one edge per cycle, registered distance write,
// per-pass change tracking. Define RELAX_FWD_EN to enable single-entry write forwarding.
module relax_writeback_stage #(
    parameter int WORD_SIZE = 8,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 pass_start,
    input  logic                 valid_in,
    input  logic                 last_edge,
    input  logic [WORD_SIZE-1:0] u_idx,
    input  logic [WORD_SIZE-1:0] in_data1,
    input  logic [WORD_SIZE-1:0] in_data2,
    input  logic [WORD_SIZE-1:0] in_data3,
    input  logic [WORD_SIZE-1:0] in_data4,
    output logic                 wr_en,
    output logic [WORD_SIZE-1:0] wr_addr,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic                 changed,
    output logic [CNT_SIZE-1:0]  relax_count,
    output logic                 pass_done,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [WORD_SIZE-1:0]      INF      = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [WORD_SIZE:0] CAND_MAX = {2'b00, {(WORD_SIZE-2){1'b1}}, 1'b0};
    localparam logic signed [WORD_SIZE:0] CAND_MIN = {2'b11, {(WORD_SIZE-1){1'b0}}};

    state_t                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [WORD_SIZE-1:0]  wr_data_q, wr_data_d;
    logic                  changed_q, changed_d;
    logic [CNT_SIZE-1:0]   relax_count_q, relax_count_d;

    logic [WORD_SIZE-1:0]  u_eff, v_eff, cand;
    logic signed [WORD_SIZE:0] sum;
    logic                  improve, start;

`ifdef RELAX_FWD_EN
    // The write retiring this cycle has not reached distance memory yet; bypass it.
    always_comb begin
        u_eff = (wr_en_q && (wr_addr_q == u_idx))    ? wr_data_q : in_data1;
        v_eff = (wr_en_q && (wr_addr_q == in_data4)) ? wr_data_q : in_data3;
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^u_idx;
    always_comb begin
        u_eff = in_data1;
        v_eff = in_data3;
    end
`endif

    always_comb begin
        sum = $signed({u_eff[WORD_SIZE-1], u_eff}) + $signed({in_data2[WORD_SIZE-1], in_data2});
        if (sum > CAND_MAX)
            cand = CAND_MAX[WORD_SIZE-1:0];
        else if (sum < CAND_MIN)
            cand = CAND_MIN[WORD_SIZE-1:0];
        else
            cand = sum[WORD_SIZE-1:0];
        improve = valid_in && (state_q == RUN) && (u_eff != INF) && ($signed(cand) < $signed(v_eff));
        start   = (state_q == IDLE) && pass_start;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (pass_start) state_d = RUN;
            RUN:   if (valid_in && last_edge) state_d = DRAIN;
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_en_d   = improve;
        wr_addr_d = improve ? in_data4 : wr_addr_q;
        wr_data_d = improve ? cand     : wr_data_q;

        changed_d     = changed_q | improve;
        relax_count_d = relax_count_q;
        if (improve && (relax_count_q != '1))
            relax_count_d = relax_count_q + CNT_SIZE'(1);
        if (start) begin
            changed_d     = 1'b0;
            relax_count_d = '0;
        end
    end

    // A stall drops the strobe so a write is never issued twice; all else holds.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= IDLE;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            changed_q     <= 1'b0;
            relax_count_q <= '0;
        end else if (enable) begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            changed_q     <= changed_d;
            relax_count_q <= relax_count_d;
        end else begin
            wr_en_q       <= 1'b0;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign changed     = changed_q;
    assign relax_count = relax_count_q;
    assign pass_done   = (state_q == DONE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_relax_writeback_stage.sv
// Directed testbench for relax_writeback_stage (counter narrowed to 4 bits so saturation is reachable).
module tb_relax_writeback_stage;

    logic       clk = 1'b0;
    logic       clear, enable, pass_start, valid_in, last_edge;
    logic [7:0] u_idx, in_data1, in_data2, in_data3, in_data4;
    logic       wr_en, changed, pass_done, busy;
    logic [7:0] wr_addr, wr_data;
    logic [3:0] relax_count;

    int total = 0;
    int bad   = 0;
    int ec    = 0;

    relax_writeback_stage #(.WORD_SIZE(8), .CNT_SIZE(4)) dut (
        .clk(clk), .clear(clear), .enable(enable), .pass_start(pass_start),
        .valid_in(valid_in), .last_edge(last_edge), .u_idx(u_idx),
        .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3), .in_data4(in_data4),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .changed(changed),
        .relax_count(relax_count), .pass_done(pass_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        pass_start = 1'b0; valid_in = 1'b0; last_edge = 1'b0;
        u_idx = 8'd200; in_data1 = '0; in_data2 = '0; in_data3 = '0; in_data4 = '0;
    endtask

    task automatic set_edge(input logic [7:0] u, input logic [7:0] w, input logic [7:0] v,
                            input logic [7:0] idx, input logic last);
        valid_in = 1'b1; last_edge = last;
        in_data1 = u; in_data2 = w; in_data3 = v; in_data4 = idx;
    endtask

    task automatic test_reset;
        clear = 1'b1; enable = 1'b1; idle_inputs();
        tick(); tick();
        clear = 1'b0;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        total++; if (wr_addr !== 8'd0 || wr_data !== 8'd0) begin bad++; $display("FAIL reset_wr_bus got %0d/%0d want 0/0", wr_addr, wr_data); end
        total++; if (changed !== 1'b0 || relax_count !== 4'd0) begin bad++; $display("FAIL reset_stats got %b/%0d want 0/0", changed, relax_count); end
        total++; if (busy !== 1'b0 || pass_done !== 1'b0) begin bad++; $display("FAIL reset_fsm got busy=%b done=%b want 0/0", busy, pass_done); end
    endtask

    task automatic test_basic;
        // Improving edge while IDLE must be ignored.
        set_edge(8'd3, 8'd2, 8'd9, 8'd5, 1'b0);
        tick();
        total++; if (wr_en !== 1'b0 || relax_count !== 4'd0) begin bad++; $display("FAIL idle_ignore got wr_en=%b cnt=%0d want 0/0", wr_en, relax_count); end
        idle_inputs(); pass_start = 1'b1;
        tick();
        pass_start = 1'b0;
        total++; if (busy !== 1'b1 || changed !== 1'b0) begin bad++; $display("FAIL start got busy=%b changed=%b want 1/0", busy, changed); end
        set_edge(8'd3, 8'd2, 8'd9, 8'd5, 1'b0);
        tick(); ec = 1;
        total++; if (wr_en !== 1'b1 || wr_addr !== 8'd5 || wr_data !== 8'd5) begin bad++; $display("FAIL basic_write got %b/%0d/%0d want 1/5/5", wr_en, wr_addr, wr_data); end
        total++; if (changed !== 1'b1 || relax_count !== 4'(ec)) begin bad++; $display("FAIL basic_stats got %b/%0d want 1/%0d", changed, relax_count, ec); end
        idle_inputs();
        tick();
        total++; if (wr_en !== 1'b0 || changed !== 1'b1) begin bad++; $display("FAIL basic_oneshot got wr_en=%b changed=%b want 0/1", wr_en, changed); end
    endtask

    task automatic test_no_improve;
        set_edge(8'h7F, 8'hFF, 8'h7F, 8'd2, 1'b0);
        tick();
        total++; if (wr_en !== 1'b0 || relax_count !== 4'(ec)) begin bad++; $display("FAIL inf_source got %b/%0d want 0/%0d", wr_en, relax_count, ec); end
        set_edge(8'd4, 8'd4, 8'd8, 8'd3, 1'b0);
        tick();
        total++; if (wr_en !== 1'b0 || relax_count !== 4'(ec)) begin bad++; $display("FAIL equal_cand got %b/%0d want 0/%0d", wr_en, relax_count, ec); end
    endtask

    task automatic test_clamp;
        set_edge(8'd120, 8'd100, 8'h7F, 8'd10, 1'b0);
        tick(); ec++;
        total++; if (wr_en !== 1'b1 || wr_data !== 8'd126 || wr_addr !== 8'd10) begin bad++; $display("FAIL clamp_hi got %b/%0d/%0d want 1/126/10", wr_en, wr_data, wr_addr); end
        set_edge(8'(-100), 8'(-100), 8'd0, 8'd11, 1'b0);
        tick(); ec++;
        total++; if (wr_en !== 1'b1 || wr_data !== 8'h80) begin bad++; $display("FAIL clamp_lo got %b/%0h want 1/80", wr_en, wr_data); end
        total++; if (relax_count !== 4'(ec)) begin bad++; $display("FAIL clamp_count got %0d want %0d", relax_count, ec); end
    endtask

    task automatic test_forward;
        set_edge(8'd0, 8'd1, 8'd50, 8'd7, 1'b0);
        tick(); ec++;
        total++; if (wr_en !== 1'b1 || wr_data !== 8'd1) begin bad++; $display("FAIL fwd_first got %b/%0d want 1/1", wr_en, wr_data); end
        set_edge(8'd0, 8'd3, 8'd50, 8'd7, 1'b0);
        tick();
`ifdef RELAX_FWD_EN
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL fwd_v got wr_en=%b want 0", wr_en); end
`else
        ec++;
        total++; if (wr_en !== 1'b1 || wr_data !== 8'd3) begin bad++; $display("FAIL nofwd_v got %b/%0d want 1/3", wr_en, wr_data); end
`endif
        set_edge(8'd5, 8'd0, 8'd50, 8'd20, 1'b0);
        tick(); ec++;
        total++; if (wr_en !== 1'b1 || wr_data !== 8'd5) begin bad++; $display("FAIL fwd_seed got %b/%0d want 1/5", wr_en, wr_data); end
        set_edge(8'd100, 8'd1, 8'd10, 8'd21, 1'b0); u_idx = 8'd20;
        tick();
`ifdef RELAX_FWD_EN
        ec++;
        total++; if (wr_en !== 1'b1 || wr_data !== 8'd6) begin bad++; $display("FAIL fwd_u got %b/%0d want 1/6", wr_en, wr_data); end
`else
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL nofwd_u got wr_en=%b want 0", wr_en); end
`endif
        total++; if (relax_count !== 4'(ec)) begin bad++; $display("FAIL fwd_count got %0d want %0d", relax_count, ec); end
        idle_inputs();
        set_edge(8'h7F, 8'd0, 8'd0, 8'd1, 1'b1);
        tick(); idle_inputs();
        total++; if (busy !== 1'b1 || pass_done !== 1'b0) begin bad++; $display("FAIL p1_drain got %b/%b want 1/0", busy, pass_done); end
        tick();
        total++; if (pass_done !== 1'b1) begin bad++; $display("FAIL p1_done got %b want 1", pass_done); end
        tick();
        total++; if (busy !== 1'b0 || pass_done !== 1'b0 || changed !== 1'b1 || relax_count !== 4'(ec)) begin
            bad++; $display("FAIL p1_idle got busy=%b done=%b ch=%b cnt=%0d want 0/0/1/%0d", busy, pass_done, changed, relax_count, ec); end
    endtask

    task automatic test_pass_end;
        idle_inputs(); pass_start = 1'b1;
        tick(); pass_start = 1'b0;
        total++; if (changed !== 1'b0 || relax_count !== 4'd0) begin bad++; $display("FAIL p2_start got %b/%0d want 0/0", changed, relax_count); end
        set_edge(8'd1, 8'd1, 8'd10, 8'd1, 1'b0); tick();
        set_edge(8'd1, 8'd1, 8'd1, 8'd2, 1'b0);  tick();
        set_edge(8'd0, 8'd0, 8'd5, 8'd3, 1'b1);  tick();
        idle_inputs();
        total++; if (wr_en !== 1'b1 || wr_data !== 8'd0 || relax_count !== 4'd2) begin bad++; $display("FAIL p2_last got %b/%0d/%0d want 1/0/2", wr_en, wr_data, relax_count); end
        total++; if (pass_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL p2_drain got done=%b busy=%b want 0/1", pass_done, busy); end
        tick();
        total++; if (pass_done !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL p2_done got done=%b wr_en=%b want 1/0", pass_done, wr_en); end
        tick();
        total++; if (pass_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL p2_idle got done=%b busy=%b want 0/0", pass_done, busy); end
    endtask

    task automatic test_stall;
        pass_start = 1'b1; tick(); pass_start = 1'b0;
        set_edge(8'd2, 8'd2, 8'd9, 8'd4, 1'b0); tick();
        // pass_start mid-pass must not reset the statistics.
        idle_inputs(); pass_start = 1'b1; tick(); pass_start = 1'b0;
        total++; if (relax_count !== 4'd1 || changed !== 1'b1) begin bad++; $display("FAIL restart_ignored got %0d/%b want 1/1", relax_count, changed); end
        set_edge(8'd2, 8'd1, 8'd9, 8'd6, 1'b1); tick(); idle_inputs();
        total++; if (wr_en !== 1'b1 || wr_data !== 8'd3 || relax_count !== 4'd2) begin bad++; $display("FAIL stall_last got %b/%0d/%0d want 1/3/2", wr_en, wr_data, relax_count); end
        enable = 1'b0;
        tick();
        total++; if (wr_en !== 1'b0 || pass_done !== 1'b0 || relax_count !== 4'd2 || wr_data !== 8'd3) begin
            bad++; $display("FAIL stall1 got wr_en=%b done=%b cnt=%0d data=%0d want 0/0/2/3", wr_en, pass_done, relax_count, wr_data); end
        tick();
        total++; if (wr_en !== 1'b0 || pass_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall2 got %b/%b/%b want 0/0/1", wr_en, pass_done, busy); end
        enable = 1'b1;
        tick();
        total++; if (pass_done !== 1'b1) begin bad++; $display("FAIL stall_done got %b want 1", pass_done); end
        tick();
        total++; if (busy !== 1'b0 || pass_done !== 1'b0) begin bad++; $display("FAIL stall_idle got %b/%b want 0/0", busy, pass_done); end
    endtask

    task automatic test_saturate;
        pass_start = 1'b1; tick(); pass_start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            set_edge(8'd0, 8'd0, 8'd1, 8'(i), 1'b0);
            tick();
            if (i == 15) begin
                total++; if (relax_count !== 4'd15) begin bad++; $display("FAIL sat_reach got %0d want 15", relax_count); end
            end
        end
        total++; if (relax_count !== 4'd15 || wr_en !== 1'b1) begin bad++; $display("FAIL sat_hold got %0d/%b want 15/1", relax_count, wr_en); end
        idle_inputs();
    endtask

    task automatic test_clear;
        // Still in RUN from the saturation pass.
        set_edge(8'd1, 8'd1, 8'd40, 8'd30, 1'b0); tick();
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL clr_pre got %b want 1", wr_en); end
        clear = 1'b1;
        set_edge(8'd1, 8'd1, 8'd40, 8'd31, 1'b0); tick();
        clear = 1'b0; idle_inputs();
        total++; if (wr_en !== 1'b0 || changed !== 1'b0 || relax_count !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL clr_mid got wr_en=%b ch=%b cnt=%0d busy=%b want 0/0/0/0", wr_en, changed, relax_count, busy); end
        total++; if (wr_addr !== 8'd0 || wr_data !== 8'd0) begin bad++; $display("FAIL clr_bus got %0d/%0d want 0/0", wr_addr, wr_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_improve();
        test_clamp();
        test_forward();
        test_pass_end();
        test_stall();
        test_saturate();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
